seq_div16x8: RTL and testbench

Sequential radix-2 restoring divider: the inverse of the team's recursive 8x8 array multiplier. It takes a 16-bit dividend (the multiplier's product width) and an 8-bit divisor, and returns a 16-bit quotient and an 8-bit remainder. It sits in the arithmetic datapath beside the multiplier family, uses valid/ready handshakes on both sides, and resolves one quotient bit per clock. Any multiplier product P = A*B with B != 0 divides back to quotient A, remainder 0.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 28 ++
 rtl/seq_div16x8.sv | 105 ++++++++++
 tb/tb_seq_div16x8.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// State encoding, operand widths and counter sizing.
package div_pkg;

   localparam int DIVIDEND_W_DFLT = 16;
   localparam int DIVISOR_W_DFLT  = 8;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CNT_W = cnt_w(DIVIDEND_W_DFLT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor if it fits, emit the quotient bit.
module div_step
   import div_pkg::*;
#(
   parameter int DIVISOR_W = DIVISOR_W_DFLT
) (
   input  logic [DIVISOR_W:0]   prem,
   input  logic [DIVISOR_W-1:0] divisor,
   input  logic                 bit_in,
   output logic [DIVISOR_W:0]   prem_nx,
   output logic                 q_bit
);

   logic [DIVISOR_W:0] shifted;
   logic [DIVISOR_W:0] trial;
   logic               borrow;

   assign shifted = {prem[DIVISOR_W-1:0], bit_in};
   assign trial   = shifted - {1'b0, divisor};

   // A set top bit means the shifted value already exceeds any divisor.
   assign borrow  = ~prem[DIVISOR_W] & (shifted < {1'b0, divisor});

   assign q_bit   = ~borrow;
   assign prem_nx = borrow ? shifted : trial;

endmodule

// File: rtl/seq_div16x8.sv
// Sequential radix-2 restoring divider, one quotient bit per clock,
// valid/ready on both sides; divide-by-zero flagged in one cycle.
module seq_div16x8
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DFLT,
   parameter int DIVISOR_W  = DIVISOR_W_DFLT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int CW = cnt_w(DIVIDEND_W);

   div_state_e state, state_nx;

   logic [DIVIDEND_W-1:0] shreg;
   logic [DIVISOR_W-1:0]  dvsr;
   logic [DIVISOR_W:0]    prem;
   logic [DIVISOR_W:0]    prem_nx;
   logic [CW-1:0]         cnt;
   logic                  dbz;
   logic                  q_bit;
   logic                  accept;
   logic                  last;
   logic                  zero_dvsr;

   assign accept    = in_valid && (state == IDLE);
   assign last      = (cnt == CW'(DIVIDEND_W - 1));
   assign zero_dvsr = (divisor == '0);

   div_step #(
      .DIVISOR_W(DIVISOR_W)
   ) u_step (
      .prem    (prem),
      .divisor (dvsr),
      .bit_in  (shreg[DIVIDEND_W-1]),
      .prem_nx (prem_nx),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (in_valid) state_nx = zero_dvsr ? DONE : BUSY;
         end
         BUSY: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         dvsr  <= '0;
         prem  <= '0;
         cnt   <= '0;
         dbz   <= 1'b0;
      end else if (accept) begin
         dvsr <= divisor;
         cnt  <= '0;
         if (zero_dvsr) begin
            shreg <= '1;
            prem  <= {1'b0, dividend[DIVISOR_W-1:0]};
            dbz   <= 1'b1;
         end else begin
            shreg <= dividend;
            prem  <= '0;
            dbz   <= 1'b0;
         end
      end else if (state == BUSY) begin
         // Quotient bits fill in from the lsb as dividend bits leave the msb.
         shreg <= {shreg[DIVIDEND_W-2:0], q_bit};
         prem  <= prem_nx;
         cnt   <= cnt + CW'(1);
      end
   end

   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign quotient    = shreg;
   assign remainder   = prem[DIVISOR_W-1:0];
   assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_div16x8.sv
// Directed and random checks for seq_div16x8.
// Each scenario task compares outputs against hand-computed values.
module tb_seq_div16x8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_div16x8 dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic start_op(input logic [15:0] a, input logic [7:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Edges after accept until out_valid; -1 if the bound expires.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         if (lat < 0) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) lat = i;
         end
      end
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero}
          !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b q=%0d r=%0d z=%b want 1 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: got rdy=%b vld=%b want 1 0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      logic [15:0] va [4] = '{16'd65025, 16'd1000, 16'd65535, 16'd5};
      logic [7:0]  vb [4] = '{8'd255, 8'd7, 8'd1, 8'd200};
      logic [15:0] eq [4] = '{16'd255, 16'd142, 16'd65535, 16'd0};
      logic [7:0]  er [4] = '{8'd0, 8'd6, 8'd0, 8'd5};
      int lat;
      for (int i = 0; i < 4; i++) begin
         start_op(va[i], vb[i]);
         wait_done(lat);
         n_cmp++;
         if (lat !== 16) begin
            n_err++;
            $display("FAIL basic_latency[%0d]: got %0d want 16", i, lat);
         end
         n_cmp++;
         if (quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result[%0d] %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=0",
                     i, va[i], vb[i], quotient, remainder, div_by_zero, eq[i], er[i]);
         end
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_in_ready_done[%0d]: got %b want 0", i, in_ready);
         end
         ack();
         n_cmp++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_back_idle[%0d]: got rdy=%b vld=%b want 1 0",
                     i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat;
      start_op(16'h04D2, 8'd0);
      wait_done(lat);
      n_cmp++;
      if (lat !== 1) begin
         n_err++;
         $display("FAIL dbz_latency: got %0d want 1", lat);
      end
      n_cmp++;
      if (quotient !== 16'hFFFF || remainder !== 8'hD2 || div_by_zero !== 1'b1) begin
         n_err++;
         $display("FAIL dbz_result: got q=%h r=%h z=%b want q=ffff r=d2 z=1",
                  quotient, remainder, div_by_zero);
      end
      ack();
      start_op(16'd20, 8'd6);
      wait_done(lat);
      n_cmp++;
      if (quotient !== 16'd3 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
         n_err++;
         $display("FAIL dbz_flag_clear: got q=%0d r=%0d z=%b want q=3 r=2 z=0",
                  quotient, remainder, div_by_zero);
      end
      ack();
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(16'd1000, 8'd7);
      wait_done(lat);
      n_cmp++;
      if (lat !== 16) begin
         n_err++;
         $display("FAIL bp_latency: got %0d want 16", lat);
      end
      dividend = 16'd50;
      divisor  = 8'd5;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             quotient !== 16'd142 || remainder !== 8'd6) begin
            n_err++;
            $display("FAIL bp_stall[%0d]: got vld=%b rdy=%b q=%0d r=%0d want 1 0 142 6",
                     c, out_valid, in_ready, quotient, remainder);
         end
      end
      in_valid = 1'b0;
      ack();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
          quotient !== 16'd142 || remainder !== 8'd6) begin
         n_err++;
         $display("FAIL bp_release: got rdy=%b vld=%b q=%0d r=%0d want 1 0 142 6",
                  in_ready, out_valid, quotient, remainder);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      start_op(16'd60000, 8'd3);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero}
          !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0}) begin
         n_err++;
         $display("FAIL midrst_outputs: got rdy=%b vld=%b q=%0d r=%0d z=%b want 1 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst = 1'b0;
      start_op(16'd100, 8'd9);
      wait_done(lat);
      n_cmp++;
      if (lat !== 16 || quotient !== 16'd11 || remainder !== 8'd1) begin
         n_err++;
         $display("FAIL midrst_next: got lat=%0d q=%0d r=%0d want 16 11 1",
                  lat, quotient, remainder);
      end
      ack();
   endtask

   task automatic test_random();
      int lat;
      int a, b;
      logic [15:0] p;
      logic [15:0] eq;
      logic [7:0]  er;
      for (int i = 0; i < 1800; i++) begin
         b = $urandom_range(1, 255);
         if (i < 1500) begin
            a  = $urandom_range(0, 255);
            p  = 16'(a * b);
            eq = 16'(a);
            er = 8'd0;
         end else begin
            p  = 16'($urandom_range(0, 65535));
            eq = p / 16'(b);
            er = 8'(p % 16'(b));
         end
         start_op(p, 8'(b));
         wait_done(lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         n_cmp++;
         if (lat !== 16 || quotient !== eq || remainder !== er ||
             div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL random[%0d] %0d/%0d: got lat=%0d q=%0d r=%0d z=%b want 16 %0d %0d 0",
                     i, p, b, lat, quotient, remainder, div_by_zero, eq, er);
         end
         ack();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
